expl_axi_sram: RTL
==================

EXPL_AXI_SRAM -- requirements
Module: expl_axi_sram
Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width (depth 2^MEM_AW 32-bit words, base 0x0 of the expl window).
REQ-002 SHALL have port clk_16M  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port expl_axi_arvalid  in  1  read address valid.
REQ-005 SHALL have port expl_axi_arready  out  1  read address ready.
REQ-006 SHALL have port expl_axi_araddr  in  `E203_ADDR_SIZE  read byte address.
REQ-007 SHALL have port expl_axi_arburst  in  2  read burst type.
REQ-008 SHALL have port expl_axi_arlen  in  4  read beats minus one.
REQ-009 SHALL have port expl_axi_arsize  in  3  read beat size.
REQ-010 SHALL have port expl_axi_awvalid  in  1  write address valid.
REQ-011 SHALL have port expl_axi_awready  out  1  write address ready.
REQ-012 SHALL have port expl_axi_awaddr  in  `E203_ADDR_SIZE  write byte address.
REQ-013 SHALL have port expl_axi_awburst  in  2  write burst type.
REQ-014 SHALL have port expl_axi_awlen  in  4  write beats minus one.
REQ-015 SHALL have port expl_axi_awsize  in  3  write beat size.
REQ-016 SHALL have port expl_axi_wvalid  in  1  write data valid.
REQ-017 SHALL have port expl_axi_wready  out  1  write data ready.
REQ-018 SHALL have port expl_axi_wdata  in  `E203_XLEN  write data.
REQ-019 SHALL have port expl_axi_wstrb  in  `E203_XLEN/8  byte enables.
REQ-020 SHALL have port expl_axi_wlast  in  1  last write beat.
REQ-021 SHALL have port expl_axi_rvalid  out  1  read data valid.
REQ-022 SHALL have port expl_axi_rready  in  1  read data ready.
REQ-023 SHALL have port expl_axi_rdata  out  `E203_XLEN  read data.
REQ-024 SHALL have port expl_axi_rresp  out  2  read response.
REQ-025 SHALL have port expl_axi_rlast  out  1  last read beat.
REQ-026 SHALL have port expl_axi_bvalid  out  1  write response valid.
REQ-027 SHALL have port expl_axi_bready  in  1  write response ready.
REQ-028 SHALL have port expl_axi_bresp  out  2  write response.
Function
REQ-029 SHALL use one FSM IDLE/RD/WR/WRESP over a single-port synchronous word RAM; one transaction at a time.
REQ-030 SHALL assert arready/awready only in IDLE; if both valid, grant alternates (round-robin flag, write wins first after reset); only granted ready is high.
REQ-031 SHALL on AR handshake (cycle N) go RD; first rvalid at N+2; each later beat rvalid one cycle after prior handshake; rdata/rresp/rlast held stable while rvalid&!rready.
REQ-032 SHALL issue arlen+1 beats, rlast on final beat, return to IDLE the cycle after final R handshake.
REQ-033 SHALL on AW handshake go WR with wready=1; each W handshake writes wdata under wstrb byte enables; beat counter (awlen+1), not wlast, ends the burst; then WRESP with bvalid=1 until bready, then IDLE.
REQ-034 SHALL step address by 1<<size per beat for INCR, hold it for FIXED; RAM index = addr[MEM_AW+1:2].
REQ-035 SHALL respond SLVERR (2'b10) on all beats, with no RAM write and rdata=0, for WRAP/reserved burst or size>2.
REQ-036 SHALL set bresp SLVERR if wlast mismatches the counted final beat (writes still performed).
REQ-037 SHALL otherwise respond OKAY (2'b00).
Reset
REQ-038 SHALL, when rst=1 at a clock edge, go IDLE, clear counters, set arready=awready=wready=rvalid=bvalid=rlast=0, rdata=0, rresp=bresp=0, abandoning any in-flight burst; RAM contents not cleared.
REQ-039 SHALL assert arready/awready in the first cycle after rst deasserts.
Configuration
REQ-040 SHALL, with EXPL_AXI_SRAM_RANGE_CHK_EN defined, respond SLVERR per beat (no write, rdata=0) when address bits above MEM_AW+1 are non-zero.
REQ-041 SHALL, without EXPL_AXI_SRAM_RANGE_CHK_EN, ignore upper address bits (aliasing modulo depth) and never flag range errors.
Verification
REQ-042 SHALL cover INCR write awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF -> bresp=OKAY; INCR read same -> 0xA0..0xA3, rlast on 4th, rresp=OKAY.
REQ-043 SHALL cover byte write addr 0x11 size=0 wstrb=0x2 data 0x0000BB00 over 0xA0 -> read 0x10 returns 0x0000BBA0.
REQ-044 SHALL cover simultaneous arvalid/awvalid after reset -> write granted first, read next; rready low 5 cycles mid-burst -> rdata held, no beat lost.
REQ-045 SHALL cover awburst=2'b10 -> bresp=SLVERR, RAM unchanged; early wlast on beat 2 of 4 -> bresp=SLVERR.
REQ-046 SHALL cover rst pulse mid read burst -> all outputs zero next cycle, arready high after release; with RANGE_CHK_EN, araddr=1<<(MEM_AW+2) -> rresp=SLVERR, rdata=0.

Source files
------------

// File: rtl/expl_axi_sram.sv
// expl_axi_sram: AXI burst slave in front of a single-port 32-bit word RAM, one transaction at a time.
// Define EXPL_AXI_SRAM_RANGE_CHK_EN to answer SLVERR for addresses above the RAM window instead of aliasing.
`ifndef E203_ADDR_SIZE
`define E203_ADDR_SIZE 32
`endif
`ifndef E203_XLEN
`define E203_XLEN 32
`endif

// state | meaning
// IDLE  | waiting for AR/AW, round-robin grant when both are valid
// RD    | streaming read beats out of the RAM
// WR    | accepting write beats, counted by the latched burst length
// WRESP | holding bvalid until bready
module expl_axi_sram #(
  parameter int MEM_AW = 10
) (
  input  logic                         clk_16M,
  input  logic                         rst,
  input  logic                         expl_axi_arvalid,
  output logic                         expl_axi_arready,
  input  logic [`E203_ADDR_SIZE-1:0]   expl_axi_araddr,
  input  logic [1:0]                   expl_axi_arburst,
  input  logic [3:0]                   expl_axi_arlen,
  input  logic [2:0]                   expl_axi_arsize,
  input  logic                         expl_axi_awvalid,
  output logic                         expl_axi_awready,
  input  logic [`E203_ADDR_SIZE-1:0]   expl_axi_awaddr,
  input  logic [1:0]                   expl_axi_awburst,
  input  logic [3:0]                   expl_axi_awlen,
  input  logic [2:0]                   expl_axi_awsize,
  input  logic                         expl_axi_wvalid,
  output logic                         expl_axi_wready,
  input  logic [`E203_XLEN-1:0]        expl_axi_wdata,
  input  logic [`E203_XLEN/8-1:0]      expl_axi_wstrb,
  input  logic                         expl_axi_wlast,
  output logic                         expl_axi_rvalid,
  input  logic                         expl_axi_rready,
  output logic [`E203_XLEN-1:0]        expl_axi_rdata,
  output logic [1:0]                   expl_axi_rresp,
  output logic                         expl_axi_rlast,
  output logic                         expl_axi_bvalid,
  input  logic                         expl_axi_bready,
  output logic [1:0]                   expl_axi_bresp
);

  localparam int AW = `E203_ADDR_SIZE;
  localparam int DW = `E203_XLEN;
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt, ld_addr;
  logic [3:0]    cnt;
  logic [2:0]    size;
  logic [1:0]    burst;
  logic          txn_err, b_err, wr_first;
  logic          ar_hs, aw_hs, w_hs, r_hs;
  logic          ld_last, ld_err, ld_rng_err, w_err, w_rng_err;
  logic [DW-1:0] mem [2**MEM_AW];

  function automatic logic bad_txn(input logic [1:0] b, input logic [2:0] s);
    return (b == 2'b10) || (b == 2'b11) || (s > 3'd2);
  endfunction

  assign ar_hs = expl_axi_arvalid && expl_axi_arready;
  assign aw_hs = expl_axi_awvalid && expl_axi_awready;
  assign w_hs  = expl_axi_wvalid && expl_axi_wready;
  assign r_hs  = expl_axi_rvalid && expl_axi_rready;

  assign addr_nxt = (burst == 2'b01) ? addr + (AW'(1) << size) : addr;
  // The first read beat uses the latched address; later beats are fetched on the prior handshake.
  assign ld_addr  = expl_axi_rvalid ? addr_nxt : addr;
  assign ld_last  = expl_axi_rvalid ? (cnt == 4'd1) : (cnt == 4'd0);

`ifdef EXPL_AXI_SRAM_RANGE_CHK_EN
  assign ld_rng_err = |ld_addr[AW-1:MEM_AW+2];
  assign w_rng_err  = |addr[AW-1:MEM_AW+2];
`else
  assign ld_rng_err = 1'b0;
  assign w_rng_err  = 1'b0;
`endif

  assign ld_err = txn_err || ld_rng_err;
  assign w_err  = txn_err || w_rng_err;

  always_ff @(posedge clk_16M) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (aw_hs) state_nxt = WR;
               else if (ar_hs) state_nxt = RD;
      RD:      if (r_hs && expl_axi_rlast) state_nxt = IDLE;
      WR:      if (w_hs && (cnt == 4'd0)) state_nxt = WRESP;
      WRESP:   if (expl_axi_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    expl_axi_arready = 1'b0;
    expl_axi_awready = 1'b0;
    expl_axi_wready  = 1'b0;
    expl_axi_bvalid  = 1'b0;
    expl_axi_bresp   = 2'b00;
    if (!rst) begin
      case (state)
        IDLE: begin
          expl_axi_awready = !(expl_axi_arvalid && expl_axi_awvalid && !wr_first);
          expl_axi_arready = !(expl_axi_arvalid && expl_axi_awvalid && wr_first);
        end
        WR:      expl_axi_wready = 1'b1;
        WRESP: begin
          expl_axi_bvalid = 1'b1;
          expl_axi_bresp  = b_err ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_16M) begin
    if (rst) begin
      addr            <= '0;
      cnt             <= '0;
      size            <= '0;
      burst           <= '0;
      txn_err         <= 1'b0;
      b_err           <= 1'b0;
      wr_first        <= 1'b1;
      expl_axi_rvalid <= 1'b0;
      expl_axi_rlast  <= 1'b0;
      expl_axi_rdata  <= '0;
      expl_axi_rresp  <= 2'b00;
    end else begin
      if (aw_hs) begin
        addr     <= expl_axi_awaddr;
        cnt      <= expl_axi_awlen;
        size     <= expl_axi_awsize;
        burst    <= expl_axi_awburst;
        txn_err  <= bad_txn(expl_axi_awburst, expl_axi_awsize);
        b_err    <= 1'b0;
        wr_first <= 1'b0;
      end else if (ar_hs) begin
        addr     <= expl_axi_araddr;
        cnt      <= expl_axi_arlen;
        size     <= expl_axi_arsize;
        burst    <= expl_axi_arburst;
        txn_err  <= bad_txn(expl_axi_arburst, expl_axi_arsize);
        wr_first <= 1'b1;
      end

      if (state == RD && (!expl_axi_rvalid || expl_axi_rready)) begin
        if (expl_axi_rvalid && expl_axi_rlast) begin
          expl_axi_rvalid <= 1'b0;
          expl_axi_rlast  <= 1'b0;
        end else begin
          expl_axi_rvalid <= 1'b1;
          expl_axi_rlast  <= ld_last;
          expl_axi_rresp  <= ld_err ? 2'b10 : 2'b00;
          expl_axi_rdata  <= ld_err ? '0 : mem[ld_addr[MEM_AW+1:2]];
          if (expl_axi_rvalid) begin
            addr <= addr_nxt;
            cnt  <= cnt - 4'd1;
          end
        end
      end

      if (w_hs) begin
        addr <= addr_nxt;
        cnt  <= cnt - 4'd1;
        // wlast is only cross-checked; the latched length decides where the burst ends.
        if (w_err || (expl_axi_wlast != (cnt == 4'd0))) b_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_16M) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < SW; b++) begin
        if (expl_axi_wstrb[b]) mem[addr[MEM_AW+1:2]][8*b +: 8] <= expl_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule
